// File: rtl/layered_objects_mux_pkg.sv
// Shared constants and helpers for the layered objects mux.
// Layer ids match the game's drawer wiring order.
package layer_mux_pkg;

    localparam int COLOR_W_DEFAULT = 8;
    localparam logic [7:0] TRANSPARENT_DEFAULT = 8'hFF;
    localparam int MAX_LAYERS = 32;

    localparam int LAYER_ENDGAME = 0;
    localparam int LAYER_PLAYER = 1;
    localparam int LAYER_HEART = 2;
    localparam int LAYER_OBJECT = 3;

    // True when at least two bits are set: clearing the lowest set bit
    // leaves something behind.
    function automatic logic popcount_ge2(
        input logic [MAX_LAYERS-1:0] v
    );
        logic [MAX_LAYERS-1:0] one;
        one = {{(MAX_LAYERS-1){1'b0}}, 1'b1};
        return |(v & (v - one));
    endfunction

endpackage

// File: rtl/layered_objects_mux_if.sv
// Pixel bus between object drawers, the layer mux and the VGA side.
// master drives layer inputs, slave is the mux.
interface layered_objects_mux_if #(
    parameter int NUM_LAYERS = 6,
    parameter int COLOR_W = 8
);

    localparam int IDX_W = $clog2(NUM_LAYERS + 1);

    logic                          startOfFrame;
    logic [NUM_LAYERS-1:0]         drawingRequest;
    logic [NUM_LAYERS*COLOR_W-1:0] layerRGB;
    logic [COLOR_W-1:0]            RGB_MIF;
    logic [NUM_LAYERS-1:0]         layerEnable;
    logic [NUM_LAYERS-1:0]         layerBlink;
    logic [COLOR_W-1:0]            RGBOut;
    logic [IDX_W-1:0]              winnerIdx;
    logic [NUM_LAYERS-1:0]         overlapMask;
    logic                          overlapValid;

    modport master (
        output startOfFrame, drawingRequest, layerRGB,
        output RGB_MIF, layerEnable, layerBlink,
        input  RGBOut, winnerIdx, overlapMask, overlapValid
    );

    modport slave (
        input  startOfFrame, drawingRequest, layerRGB,
        input  RGB_MIF, layerEnable, layerBlink,
        output RGBOut, winnerIdx, overlapMask, overlapValid
    );

endinterface

// File: rtl/layered_objects_mux_priority_enc.sv
// Lowest-index-first priority encoder.
// idx is N (one past the last layer) when nothing is requested.
module layer_priority_enc #(
    parameter int N = 6,
    parameter int IW = $clog2(N + 1)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top so the lowest set index is the last to win.
    always_comb begin
        idx = IW'(N);
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layered_objects_mux.sv
// Two-stage prioritised layer mux with enable, blink, colour keying
// and per-frame overlap reporting for collision detection.
module layered_objects_mux
    import layer_mux_pkg::*;
#(
    parameter int NUM_LAYERS = 6,
    parameter int COLOR_W = COLOR_W_DEFAULT,
    parameter logic [COLOR_W-1:0] TRANSPARENT =
        COLOR_W'(TRANSPARENT_DEFAULT),
    parameter int BLINK_W = 5
) (
    input logic clk,
    input logic resetN,
    layered_objects_mux_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_LAYERS + 1);
    localparam int RGB_W = NUM_LAYERS * COLOR_W;

    logic [BLINK_W-1:0]    frame_cnt;
    logic                  blink_phase;
    logic [NUM_LAYERS-1:0] qual;
    logic [NUM_LAYERS-1:0] contrib;
    logic [NUM_LAYERS-1:0] acc;
    logic [NUM_LAYERS-1:0] overlap_mask;
    logic                  overlap_valid;

    logic [NUM_LAYERS-1:0] qual_s1;
    logic [RGB_W-1:0]      rgb_s1;
    logic [COLOR_W-1:0]    mif_s1;

    logic [IDX_W-1:0]      win;
    logic                  win_valid;
    logic [COLOR_W-1:0]    sel_rgb;
    logic [COLOR_W-1:0]    rgb_out;
    logic [IDX_W-1:0]      winner_idx;

    assign blink_phase = frame_cnt[BLINK_W-1];

    // A layer competes only if requested, enabled, opaque and not blinked off.
    always_comb begin
        qual = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            qual[i] = bus.drawingRequest[i]
                    & bus.layerEnable[i]
                    & (bus.layerRGB[i*COLOR_W +: COLOR_W] != TRANSPARENT)
                    & ~(bus.layerBlink[i] & blink_phase);
        end
    end

    // Only pixels where two or more layers coincide feed the accumulator.
    always_comb begin
        contrib = '0;
        if (popcount_ge2(MAX_LAYERS'(qual))) begin
            contrib = qual;
        end
    end

    // Frame counter drives blink; the new phase applies from the next pixel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (bus.startOfFrame) begin
            frame_cnt <= frame_cnt + BLINK_W'(1);
        end
    end

    // Overlap accumulator; the pulse cycle closes one frame and opens the next.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc <= '0;
            overlap_mask <= '0;
            overlap_valid <= 1'b0;
        end else if (bus.startOfFrame) begin
            overlap_mask <= acc | contrib;
            acc <= contrib;
            overlap_valid <= 1'b1;
        end else begin
            acc <= acc | contrib;
            overlap_valid <= 1'b0;
        end
    end

    // Stage 1: qualification result plus the colours that go with it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            qual_s1 <= '0;
            rgb_s1 <= '0;
            mif_s1 <= '0;
        end else begin
            qual_s1 <= qual;
            rgb_s1 <= bus.layerRGB;
            mif_s1 <= bus.RGB_MIF;
        end
    end

    layer_priority_enc #(
        .N (NUM_LAYERS),
        .IW(IDX_W)
    ) u_enc (
        .req  (qual_s1),
        .idx  (win),
        .valid(win_valid)
    );

    // Winner's colour, or the background when no layer qualifies.
    always_comb begin
        sel_rgb = mif_s1;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (win_valid && (win == IDX_W'(i))) begin
                sel_rgb = rgb_s1[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Stage 2: registered pixel colour and winning layer index.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_out <= '0;
            winner_idx <= IDX_W'(NUM_LAYERS);
        end else begin
            rgb_out <= sel_rgb;
            winner_idx <= win;
        end
    end

    assign bus.RGBOut = rgb_out;
    assign bus.winnerIdx = winner_idx;
    assign bus.overlapMask = overlap_mask;
    assign bus.overlapValid = overlap_valid;

endmodule

// File: tb/tb_layered_objects_mux.sv
// Scoreboard bench for layered_objects_mux (6 layers, 2-bit blink counter).
// Expected pixels are queued at drive time and popped when due.
module tb_layered_objects_mux;

    localparam int NL = 6;

    typedef struct {
        int         due;
        logic [7:0] rgb;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   cyc = 0;

    logic          sof = 1'b0;
    logic [NL-1:0] req = '0;
    logic [NL-1:0] en = '1;
    logic [NL-1:0] blink = '0;
    logic [7:0]    mif = 8'h00;
    logic [47:0]   cols = '0;

    logic [1:0]    m_cnt = '0;
    logic [NL-1:0] m_acc = '0;
    logic [NL-1:0] m_mask = '0;
    logic          m_valid = 1'b0;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    layered_objects_mux_if #(.NUM_LAYERS(NL), .COLOR_W(8)) bus ();

    assign bus.startOfFrame = sof;
    assign bus.drawingRequest = req;
    assign bus.layerRGB = cols;
    assign bus.RGB_MIF = mif;
    assign bus.layerEnable = en;
    assign bus.layerBlink = blink;

    layered_objects_mux #(
        .NUM_LAYERS (NL),
        .COLOR_W    (8),
        .TRANSPARENT(8'hFF),
        .BLINK_W    (2)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic set_col(input int i, input logic [7:0] v);
        cols[i*8 +: 8] = v;
    endtask

    task automatic default_cols();
        set_col(0, 8'h10);
        set_col(1, 8'h20);
        set_col(2, 8'h1C);
        set_col(3, 8'hE0);
        set_col(4, 8'h44);
        set_col(5, 8'h5A);
    endtask

    // One pixel: queue the expectation, clock it, check what is due.
    task automatic tick();
        logic [NL-1:0] q;
        logic [7:0]    erg;
        logic [2:0]    eidx;
        logic [NL-1:0] c;
        exp_t          e;
        for (int i = 0; i < NL; i++) begin
            q[i] = req[i] && en[i] && (cols[i*8 +: 8] !== 8'hFF)
                   && !(blink[i] && m_cnt[1]);
        end
        erg = mif;
        eidx = 3'd6;
        for (int i = 0; i < NL; i++) begin
            if (q[i]) begin
                erg = cols[i*8 +: 8];
                eidx = 3'(i);
                break;
            end
        end
        sbq.push_back('{cyc + 2, erg, eidx});
        c = ($countones(q) >= 2) ? q : '0;
        if (sof) begin
            m_mask = m_acc | c;
            m_acc = c;
            m_valid = 1'b1;
            m_cnt = m_cnt + 2'd1;
        end else begin
            m_acc = m_acc | c;
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.overlapValid !== m_valid || bus.overlapMask !== m_mask) begin
            n_bad++;
            $display("FAIL sb_overlap cyc=%0d got v=%b m=%b want v=%b m=%b",
                     cyc, bus.overlapValid, bus.overlapMask, m_valid, m_mask);
        end
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            n_cmp++;
            if (e.due != cyc || bus.RGBOut !== e.rgb
                || bus.winnerIdx !== e.idx) begin
                n_bad++;
                $display("FAIL sb_pixel cyc=%0d got %h/%0d want %h/%0d",
                         cyc, bus.RGBOut, bus.winnerIdx, e.rgb, e.idx);
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetN = 1'b1;
        sbq.delete();
        m_cnt = '0;
        m_acc = '0;
        m_mask = '0;
        m_valid = 1'b0;
        sbq.push_back('{cyc + 1, 8'h00, 3'd6});
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        default_cols();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.RGBOut !== 8'h00 || bus.winnerIdx !== 3'd6
            || bus.overlapMask !== 6'b0 || bus.overlapValid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got %h/%0d/%b/%b want 00/6/0/0",
                     bus.RGBOut, bus.winnerIdx, bus.overlapMask,
                     bus.overlapValid);
        end
        release_reset();
    endtask

    task automatic test_blink();
        int c;
        set_col(1, 8'h55);
        blink = 6'b000010;
        req = 6'b000010;
        mif = 8'h00;
        for (int f = 0; f < 8; f++) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            repeat (3) tick();
            c = (f + 1) % 4;
            n_cmp++;
            if (bus.winnerIdx !== ((c < 2) ? 3'd1 : 3'd6)
                || bus.RGBOut !== ((c < 2) ? 8'h55 : 8'h00)) begin
                n_bad++;
                $display("FAIL blink frame=%0d cnt=%0d got %h/%0d", f, c,
                         bus.RGBOut, bus.winnerIdx);
            end
        end
        blink = '0;
        default_cols();
    endtask

    task automatic test_priority();
        req = '0;
        mif = 8'h00;
        tick();
        req = 6'b001100;
        tick();
        n_cmp++;
        if (bus.RGBOut !== 8'h00 || bus.winnerIdx !== 3'd6) begin
            n_bad++;
            $display("FAIL prio_early got %h/%0d want 00/6",
                     bus.RGBOut, bus.winnerIdx);
        end
        tick();
        n_cmp++;
        if (bus.RGBOut !== 8'h1C || bus.winnerIdx !== 3'd2) begin
            n_bad++;
            $display("FAIL prio got %h/%0d want 1c/2",
                     bus.RGBOut, bus.winnerIdx);
        end
    endtask

    task automatic test_transparent();
        req = 6'b000011;
        mif = 8'h24;
        set_col(0, 8'hFF);
        set_col(1, 8'h03);
        repeat (2) tick();
        n_cmp++;
        if (bus.RGBOut !== 8'h03 || bus.winnerIdx !== 3'd1) begin
            n_bad++;
            $display("FAIL transp_fall got %h/%0d want 03/1",
                     bus.RGBOut, bus.winnerIdx);
        end
        set_col(1, 8'hFF);
        repeat (2) tick();
        n_cmp++;
        if (bus.RGBOut !== 8'h24 || bus.winnerIdx !== 3'd6) begin
            n_bad++;
            $display("FAIL transp_all got %h/%0d want 24/6",
                     bus.RGBOut, bus.winnerIdx);
        end
        default_cols();
    endtask

    task automatic test_enable();
        en = 6'b111110;
        req = 6'b000001;
        mif = 8'h49;
        repeat (2) tick();
        n_cmp++;
        if (bus.RGBOut !== 8'h49 || bus.winnerIdx !== 3'd6) begin
            n_bad++;
            $display("FAIL enable got %h/%0d want 49/6",
                     bus.RGBOut, bus.winnerIdx);
        end
        en = '1;
        req = '0;
    endtask

    task automatic test_overlap();
        req = '0;
        sof = 1'b1;
        tick();
        sof = 1'b0;
        req = 6'b010010;
        tick();
        req = '0;
        sof = 1'b1;
        tick();
        n_cmp++;
        if (bus.overlapValid !== 1'b1 || bus.overlapMask !== 6'b010010) begin
            n_bad++;
            $display("FAIL overlap_hit got v=%b m=%b want 1/010010",
                     bus.overlapValid, bus.overlapMask);
        end
        sof = 1'b0;
        req = 6'b000100;
        tick();
        n_cmp++;
        if (bus.overlapValid !== 1'b0) begin
            n_bad++;
            $display("FAIL overlap_pulse got v=%b want 0", bus.overlapValid);
        end
        tick();
        sof = 1'b1;
        tick();
        n_cmp++;
        if (bus.overlapValid !== 1'b1 || bus.overlapMask !== 6'b000000) begin
            n_bad++;
            $display("FAIL overlap_none got v=%b m=%b want 1/000000",
                     bus.overlapValid, bus.overlapMask);
        end
        sof = 1'b0;
        req = '0;
    endtask

    task automatic test_back_to_back();
        req = 6'b000110;
        tick();
        sof = 1'b1;
        req = 6'b000001;
        tick();
        n_cmp++;
        if (bus.overlapValid !== 1'b1 || bus.overlapMask !== 6'b000110) begin
            n_bad++;
            $display("FAIL b2b_first got v=%b m=%b want 1/000110",
                     bus.overlapValid, bus.overlapMask);
        end
        req = 6'b000110;
        tick();
        n_cmp++;
        if (bus.overlapValid !== 1'b1 || bus.overlapMask !== 6'b000110) begin
            n_bad++;
            $display("FAIL b2b_second got v=%b m=%b want 1/000110",
                     bus.overlapValid, bus.overlapMask);
        end
        sof = 1'b0;
        req = '0;
        tick();
        n_cmp++;
        if (bus.overlapValid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end got v=%b want 0", bus.overlapValid);
        end
    endtask

    task automatic test_mid_reset();
        mif = 8'h00;
        req = 6'b100001;
        tick();
        req = 6'b001000;
        repeat (2) tick();
        n_cmp++;
        if (bus.RGBOut !== 8'hE0) begin
            n_bad++;
            $display("FAIL mid_pre got %h want e0", bus.RGBOut);
        end
        resetN = 1'b0;
        #1;
        n_cmp++;
        if (bus.RGBOut !== 8'h00 || bus.winnerIdx !== 3'd6) begin
            n_bad++;
            $display("FAIL mid_async got %h/%0d want 00/6",
                     bus.RGBOut, bus.winnerIdx);
        end
        repeat (2) @(posedge clk);
        release_reset();
        req = 6'b000100;
        tick();
        n_cmp++;
        if (bus.RGBOut !== 8'h00 || bus.winnerIdx !== 3'd6) begin
            n_bad++;
            $display("FAIL post_rst1 got %h/%0d want 00/6",
                     bus.RGBOut, bus.winnerIdx);
        end
        tick();
        n_cmp++;
        if (bus.RGBOut !== 8'h1C || bus.winnerIdx !== 3'd2) begin
            n_bad++;
            $display("FAIL post_rst2 got %h/%0d want 1c/2",
                     bus.RGBOut, bus.winnerIdx);
        end
        req = 6'b010010;
        tick();
        req = '0;
        sof = 1'b1;
        tick();
        n_cmp++;
        if (bus.overlapValid !== 1'b1 || bus.overlapMask !== 6'b010010) begin
            n_bad++;
            $display("FAIL partial_frame got v=%b m=%b want 1/010010",
                     bus.overlapValid, bus.overlapMask);
        end
        sof = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_blink();
        test_priority();
        test_transparent();
        test_enable();
        test_overlap();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/layered_objects_mux.md
Name: layered_objects_mux

Overview:
- Parametrised successor to the fixed five-source VGA priority mux.
- Selects one RGB value per pixel from NUM_LAYERS drawing sources. Layer 0 has the highest priority. The background (MIF) is used when no layer wins.
- Adds per-layer enable, per-layer blink driven by a frame counter, transparent-colour keying, a 2-stage pipeline, and per-frame overlap reporting that game logic uses for collision detection.
- Sits between the object drawers and the VGA controller.

Parameters:
- NUM_LAYERS, 6, number of prioritised drawing sources; index 0 is the highest priority.
- COLOR_W, 8, width of each RGB value (RRRGGGBB).
- TRANSPARENT, 8'hFF, layer colour that is treated as "no request" even when the layer's request bit is 1.
- BLINK_W, 5, width of the frame counter; the blink period is 2^BLINK_W frames.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- drawingRequest  in  NUM_LAYERS  per-layer request; bit i belongs to layer i.
- layerRGB  in  NUM_LAYERS*COLOR_W  packed colours; layer i occupies [i*COLOR_W +: COLOR_W].
- RGB_MIF  in  COLOR_W  background colour.
- layerEnable  in  NUM_LAYERS  static mask; a 0 bit removes that layer entirely.
- layerBlink  in  NUM_LAYERS  a 1 bit makes that layer subject to blink gating.
- RGBOut  out  COLOR_W  selected colour, registered.
- winnerIdx  out  $clog2(NUM_LAYERS+1)  winning layer index; the value NUM_LAYERS means background.
- overlapMask  out  NUM_LAYERS  layers that were co-visible with any other layer during the previous frame.
- overlapValid  out  1  one-cycle pulse when overlapMask is updated.

Behaviour:
- Reset (asynchronous, resetN=0): RGBOut=0, winnerIdx=NUM_LAYERS, overlapMask=0, overlapValid=0, frame counter=0, all pipeline registers=0.
- Stage 1 (registered):
  - qualified[i] = drawingRequest[i] & layerEnable[i] & (layerRGB_i != TRANSPARENT) & ~(layerBlink[i] & blinkPhase).
  - The stage also registers all layer colours and RGB_MIF alongside qualified.
- Stage 2 (registered): priority-encode qualified, choosing the lowest set index.
  - RGBOut takes the winner's colour, or the stage-1 RGB_MIF copy if nothing is qualified.
  - winnerIdx is updated in the same cycle.
- Latency: inputs sampled at edge N appear on RGBOut after edge N+2. The latency is fixed with no bubbles; there is no stall input.
- Frame counter:
  - Increments on each cycle where startOfFrame=1 and wraps modulo 2^BLINK_W.
  - blinkPhase = counter MSB, which is combinational from the registered counter.
  - A blink change takes effect on the pixel sampled in the same cycle as the pulse only after the increment, i.e. from the next cycle onward.
- Overlap accumulator:
  - Each cycle where popcount(qualified) >= 2, accumulate |= qualified.
  - On startOfFrame: overlapMask <= accumulator, including the current-cycle contribution. The accumulator then clears and restarts from the current cycle's qualified contribution only if that contribution has 2 or more bits set. overlapValid=1 for that single cycle.
  - overlapValid is otherwise 0.
- Boundary rules:
  - All requests 0, or all layers disabled/transparent/blinked-off: background colour, winnerIdx=NUM_LAYERS.
  - A layer whose colour equals TRANSPARENT falls through to the next layer, not to the background.
  - Two startOfFrame pulses in consecutive cycles: each produces an overlapValid pulse; the second reports only one cycle of accumulation.
  - Reset mid-frame discards the accumulator; the first post-reset frame report covers only the partial frame.
  - NUM_LAYERS=1 must elaborate; overlapMask is then always 0.

Decomposition:
- Package layer_mux_pkg:
  - COLOR_W_DEFAULT and TRANSPARENT_DEFAULT.
  - Layer index constants LAYER_ENDGAME=0, LAYER_PLAYER=1, LAYER_HEART=2, LAYER_OBJECT=3.
  - A function popcount_ge2.
- Sub-module layer_priority_enc:
  - Parametrised on width N.
  - Combinational lowest-index-first encoder.
  - Outputs index and a valid flag.
  - Instantiated in stage 2.

Test Plan:
- Priority: NUM_LAYERS=6, requests 6'b001100, colours L2=8'h1C, L3=8'hE0. Required: RGBOut=8'h1C and winnerIdx=2, exactly 2 cycles after the inputs.
- Transparency fall-through: requests 6'b000011, L0=8'hFF, L1=8'h03. Required: RGBOut=8'h03, winnerIdx=1. With L1 also set to 8'hFF: RGBOut=RGB_MIF, winnerIdx=6.
- Enable mask: layerEnable=6'b111110, request 6'b000001, RGB_MIF=8'h49. Required: RGBOut=8'h49, winnerIdx=6.
- Blink: BLINK_W=2, layerBlink[1]=1, request L1 continuously, 8 startOfFrame pulses. Required: L1 is visible for frames where counter is 0–1, suppressed for counter 2–3, and the pattern repeats.
- Overlap report: one frame with a single cycle of requests 6'b010010, then startOfFrame. Required: overlapMask=6'b010010 with a one-cycle overlapValid. Next frame with no overlap: overlapMask=0.
- Asynchronous reset asserted mid-pipeline while RGBOut=8'hE0. Required: RGBOut=0 and winnerIdx=6 immediately, without a clock edge. After release, the first valid output appears 2 cycles after the first sampled input.
